// File: rtl/rgb565_burst_writer_pkg.sv
// Shared types and constants for the RGB565 frame-buffer burst writer.
// Holds the write FSM encoding, pixel/word widths, frame geometry and the pixel conversion.
package rgb565_burst_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam int RGB565_W       = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int FRAME_H_PIX    = 640;
    localparam int FRAME_V_PIX    = 480;

    // Keep the top bits of each 12-bit channel; plain truncation, no rounding.
    function automatic logic [RGB565_W-1:0] to_rgb565(input logic [11:0] r,
                                                      input logic [11:0] g,
                                                      input logic [11:0] b);
        return {5'(r >> 7), 6'(g >> 6), 5'(b >> 7)};
    endfunction

endpackage

// File: rtl/rgb565_burst_writer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head word is always visible on dout.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rgb565_burst_writer.sv
// Packs pairs of RGB565 pixels into 32-bit words and writes them to the frame buffer
// as fixed-length incrementing AXI write bursts, wrapping at the end of each frame.
module rgb565_burst_writer
    import rgb565_burst_writer_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                BURST_LEN   = 8,
    parameter int                FIFO_DEPTH  = 16,
    parameter int                FRAME_WORDS = 153600
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [11:0]       iRed,
    input  logic [11:0]       iGreen,
    input  logic [11:0]       iBlue,
    input  logic              iDVAL,
    input  logic [10:0]       iX_Cont,
    input  logic [10:0]       iY_Cont,
    output logic [ADDR_W-1:0] oAWADDR,
    output logic [7:0]        oAWLEN,
    output logic              oAWVALID,
    input  logic              iAWREADY,
    output logic [31:0]       oWDATA,
    output logic              oWLAST,
    output logic              oWVALID,
    input  logic              iWREADY,
    input  logic              iBVALID,
    output logic              oBREADY,
    output logic              oOVERFLOW,
    output logic              oFRAME_DONE,
    output wr_state_t         oDBG_STATE
);

    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES_PER_WORD);
    localparam logic [3:0]        LAST_BEAT   = 4'(BURST_LEN - 1);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1;
    // once raised, valid and its payload stay stable until that edge.

    logic [RGB565_W-1:0] px;
    logic                frame_start;
    logic                half_valid;
    logic [RGB565_W-1:0] half_px;
    logic                restart_pend;
    logic                push;
    logic                pop;

    logic [31:0]         fifo_dout;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    wr_state_t           state;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   idle_addr;
    logic [31:0]         word_cnt;
    logic [31:0]         next_word_cnt;
    logic [3:0]          beat;
    logic [ADDR_W-1:0]   awaddr_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                wlast_q;
    logic                bready_q;
    logic                frame_done_q;
    logic                overflow_q;

    assign px          = to_rgb565(iRed, iGreen, iBlue);
    assign frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign push        = iDVAL && !frame_start && half_valid;
    assign pop         = wvalid_q && iWREADY && !fifo_empty;

    // Pair packing; a frame-start pixel always opens a fresh pair and requests an address restart.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            half_valid   <= 1'b0;
            half_px      <= '0;
            restart_pend <= 1'b0;
        end else begin
            if (frame_start) begin
                half_px    <= px;
                half_valid <= 1'b1;
            end else if (iDVAL) begin
                if (half_valid) begin
                    half_valid <= 1'b0;
                end else begin
                    half_px    <= px;
                    half_valid <= 1'b1;
                end
            end
            if (frame_start)             restart_pend <= 1'b1;
            else if (state == ST_IDLE)   restart_pend <= 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                               overflow_q <= 1'b0;
        else if (push && fifo_full && !pop)     overflow_q <= 1'b1;
    end

    sync_fifo_fwft #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (push),
        .din   ({px, half_px}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign idle_addr     = restart_pend ? BASE_ADDR : addr_q;
    assign next_word_cnt = word_cnt + 32'(BURST_LEN);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state        <= ST_IDLE;
            addr_q       <= BASE_ADDR;
            word_cnt     <= '0;
            beat         <= '0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (restart_pend) begin
                        addr_q   <= BASE_ADDR;
                        word_cnt <= '0;
                    end
                    if (fifo_count >= CNT_W'(BURST_LEN)) begin
                        state     <= ST_ADDR;
                        awvalid_q <= 1'b1;
                        awaddr_q  <= idle_addr;
                    end
                end
                ST_ADDR: begin
                    if (iAWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= 1'b0;
                        beat      <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (iWREADY) begin
                        beat <= beat + 4'd1;
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            wlast_q <= ((beat + 4'd1) == LAST_BEAT);
                        end
                    end
                end
                ST_RESP: begin
                    if (iBVALID) begin
                        bready_q <= 1'b0;
                        state    <= ST_IDLE;
                        if (next_word_cnt == 32'(FRAME_WORDS)) begin
                            frame_done_q <= 1'b1;
                            addr_q       <= BASE_ADDR;
                            word_cnt     <= '0;
                        end else begin
                            addr_q   <= addr_q + BURST_BYTES;
                            word_cnt <= next_word_cnt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oAWADDR     = awaddr_q;
    assign oAWLEN      = 8'(BURST_LEN - 1);
    assign oAWVALID    = awvalid_q;
    assign oWDATA      = wvalid_q ? fifo_dout : '0;
    assign oWLAST      = wlast_q;
    assign oWVALID     = wvalid_q;
    assign oBREADY     = bready_q;
    assign oOVERFLOW   = overflow_q;
    assign oFRAME_DONE = frame_done_q;
    assign oDBG_STATE  = state;

endmodule

// File: tb/tb_rgb565_burst_writer.sv
// Bench for rgb565_burst_writer: a transaction-level model of pixels, packed words,
// bursts and frame addressing, compared against the DUT on every falling clock edge.
module tb_rgb565_burst_writer;
    import rgb565_burst_writer_pkg::*;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          BL     = 8;
    localparam int          DEPTH  = 16;
    localparam int          FW     = 16;

    logic        iCLK, iRST;
    logic [11:0] iRed, iGreen, iBlue;
    logic        iDVAL;
    logic [10:0] iX_Cont, iY_Cont;
    logic [31:0] oAWADDR;
    logic [7:0]  oAWLEN;
    logic        oAWVALID, iAWREADY;
    logic [31:0] oWDATA;
    logic        oWLAST, oWVALID, iWREADY, iBVALID, oBREADY;
    logic        oOVERFLOW, oFRAME_DONE;
    wr_state_t   oDBG_STATE;

    rgb565_burst_writer #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (DEPTH),
        .FRAME_WORDS (FW)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iRed        (iRed),
        .iGreen      (iGreen),
        .iBlue       (iBlue),
        .iDVAL       (iDVAL),
        .iX_Cont     (iX_Cont),
        .iY_Cont     (iY_Cont),
        .oAWADDR     (oAWADDR),
        .oAWLEN      (oAWLEN),
        .oAWVALID    (oAWVALID),
        .iAWREADY    (iAWREADY),
        .oWDATA      (oWDATA),
        .oWLAST      (oWLAST),
        .oWVALID     (oWVALID),
        .iWREADY     (iWREADY),
        .iBVALID     (iBVALID),
        .oBREADY     (oBREADY),
        .oOVERFLOW   (oOVERFLOW),
        .oFRAME_DONE (oFRAME_DONE),
        .oDBG_STATE  (oDBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    bit          have_low;
    logic [15:0] low_px;
    bit          restart_m;
    bit          ovf_m;
    bit          fd_m;
    int          phase;      // 0 no burst, 1 address, 2 data, 3 response
    int          beat_m;
    logic [31:0] addr_m;
    logic [31:0] burst_addr_m;
    int          words_m;
    int          fd_count, aw_hi, b_hi;

    bit rnd_mode;
    bit w_stall;
    int aw_delay, b_delay;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] px565(input logic [11:0] r, input logic [11:0] g,
                                          input logic [11:0] b);
        int v;
        v = (int'(r) / 128) * 2048 + (int'(g) / 64) * 32 + (int'(b) / 128);
        return 16'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        have_low  = 0;
        low_px    = '0;
        restart_m = 0;
        ovf_m     = 0;
        fd_m      = 0;
        phase     = 0;
        beat_m    = 0;
        addr_m    = BASE;
        burst_addr_m = BASE;
        words_m   = 0;
    endtask

    // ---------------- compare process ----------------
    initial begin
        int cur;
        bit do_pop;
        logic [15:0] v;
        model_reset();
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                chk("rst_awvalid", 32'(oAWVALID), 0);
                chk("rst_wvalid", 32'(oWVALID), 0);
                chk("rst_bready", 32'(oBREADY), 0);
                chk("rst_wlast", 32'(oWLAST), 0);
                chk("rst_awaddr", oAWADDR, 0);
                chk("rst_wdata", oWDATA, 0);
                chk("rst_ovf", 32'(oOVERFLOW), 0);
                chk("rst_fdone", 32'(oFRAME_DONE), 0);
                chk("rst_awlen", 32'(oAWLEN), BL - 1);
                chk("rst_state", 32'(oDBG_STATE), 32'(ST_IDLE));
                model_reset();
            end else begin
                cur = phase;
                chk("awvalid", 32'(oAWVALID), 32'(cur == 1));
                chk("wvalid", 32'(oWVALID), 32'(cur == 2));
                chk("bready", 32'(oBREADY), 32'(cur == 3));
                chk("frame_done", 32'(oFRAME_DONE), 32'(fd_m));
                chk("overflow", 32'(oOVERFLOW), 32'(ovf_m));
                chk("awlen", 32'(oAWLEN), BL - 1);
                if (cur == 1) chk("awaddr", oAWADDR, burst_addr_m);
                if (cur == 2) begin
                    if (exp_q.size() == 0) chk("wdata_underrun", 32'(exp_q.size()), 1);
                    else chk("wdata", oWDATA, exp_q[0]);
                    chk("wlast", 32'(oWLAST), 32'(beat_m == BL - 1));
                end
                fd_m = 0;
                aw_hi += int'(oAWVALID);
                b_hi  += int'(oBREADY);
                fd_count += int'(oFRAME_DONE);

                // burst bookkeeping for the edge that follows
                do_pop = 0;
                case (cur)
                    0: begin
                        if (restart_m) begin
                            addr_m    = BASE;
                            words_m   = 0;
                            restart_m = 0;
                        end
                        if (exp_q.size() >= BL) begin
                            phase = 1;
                            burst_addr_m = addr_m;
                        end
                    end
                    1: if (iAWREADY) begin
                        aw_log.push_back(oAWADDR);
                        phase  = 2;
                        beat_m = 0;
                    end
                    2: if (iWREADY) begin
                        w_log.push_back(oWDATA);
                        do_pop = 1;
                        if (beat_m == BL - 1) phase = 3;
                        beat_m++;
                    end
                    default: if (iBVALID) begin
                        phase = 0;
                        words_m += BL;
                        if (words_m == FW) begin
                            words_m = 0;
                            addr_m  = BASE;
                            fd_m    = 1;
                        end else begin
                            addr_m = addr_m + BL * 4;
                        end
                    end
                endcase
                if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());

                if (iDVAL) begin
                    v = px565(iRed, iGreen, iBlue);
                    if (iX_Cont == 0 && iY_Cont == 0) begin
                        low_px    = v;
                        have_low  = 1;
                        restart_m = 1;
                    end else if (!have_low) begin
                        low_px   = v;
                        have_low = 1;
                    end else begin
                        have_low = 0;
                        if (exp_q.size() >= DEPTH) ovf_m = 1;
                        else exp_q.push_back({v, low_px});
                    end
                end
            end
        end
    end

    // ---------------- response-side driver ----------------
    initial begin
        int aw_cnt = 0;
        int b_cnt  = 0;
        iAWREADY = 1'b0;
        iWREADY  = 1'b0;
        iBVALID  = 1'b0;
        forever begin
            @(posedge iCLK);
            #1;
            aw_cnt = oAWVALID ? aw_cnt + 1 : 0;
            b_cnt  = oBREADY ? b_cnt + 1 : 0;
            iAWREADY = rnd_mode ? 1'($urandom_range(0, 1)) : (aw_cnt > aw_delay);
            iBVALID  = rnd_mode ? 1'($urandom_range(0, 1)) : (b_cnt > b_delay);
            iWREADY  = w_stall ? 1'b0 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- pixel driver tasks ----------------
    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_px(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                            input logic [10:0] x, input logic [10:0] y);
        iDVAL = 1'b1; iRed = r; iGreen = g; iBlue = b; iX_Cont = x; iY_Cont = y;
        cyc();
    endtask

    task automatic rand_px();
        drive_px(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                 12'($urandom_range(0, 4095)), 11'($urandom_range(1, 639)),
                 11'($urandom_range(0, 479)));
    endtask

    task automatic idle(input int n);
        iDVAL = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        iDVAL = 1'b0;
        iRST  = 1'b1;
        repeat (2) cyc();
        iRST = 1'b0;
        cyc();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        iDVAL = 1'b0;
        while (!(phase == 0 && exp_q.size() < BL) && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(n < budget), 1);
        repeat (3) cyc();
    endtask

    task automatic wait_wvalid(input string name, input int budget);
        int n = 0;
        while (!oWVALID && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(oWVALID), 1);
    endtask

    task automatic clear_logs();
        aw_log.delete();
        w_log.delete();
        fd_count = 0;
        aw_hi    = 0;
        b_hi     = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
        iX_Cont = '0; iY_Cont = '0;
        rnd_mode = 0; w_stall = 0; aw_delay = 0; b_delay = 0;
        repeat (3) cyc();
        iRST = 1'b0;
        cyc();

        chk("pin_px_red", 32'(px565(12'hFFF, 12'h000, 12'h000)), 32'h0000_F800);
        chk("pin_px_green", 32'(px565(12'h000, 12'hFFF, 12'h000)), 32'h0000_07E0);
        chk("pin_px_mixed", 32'(px565(12'h87F, 12'h0C3, 12'hF80)), 32'h0000_807F);

        // two full bursts of pure red, ending the shortened frame
        clear_logs();
        for (int i = 0; i < 32; i++) drive_px(12'hFFF, 12'h000, 12'h000, 11'(i + 1), 11'd1);
        drain("t1_drain", 200);
        chk("t1_bursts", 32'(aw_log.size()), 2);
        if (aw_log.size() >= 2) begin
            chk("t1_addr0", aw_log[0], BASE);
            chk("t1_addr1", aw_log[1], BASE + 32'h20);
        end
        chk("t1_beats", 32'(w_log.size()), 16);
        foreach (w_log[i]) chk("t1_wdata", w_log[i], 32'hF800_F800);
        chk("t1_frame_done", 32'(fd_count), 1);

        // write backpressure while the FIFO overfills
        clear_logs();
        for (int i = 0; i < 16; i++) rand_px();
        idle(0);
        wait_wvalid("t2_wvalid", 50);
        repeat (2) cyc();
        w_stall = 1;
        for (int i = 0; i < 40; i++) rand_px();
        idle(4);
        w_stall = 0;
        drain("t2_drain", 300);
        chk("t2_overflow", 32'(oOVERFLOW), 1);
        if (aw_log.size() >= 1) chk("t2_wrap_addr", aw_log[0], BASE);
        idle(10);
        chk("t2_overflow_sticky", 32'(oOVERFLOW), 1);

        // frame start on an odd pixel count restarts packing and addressing
        do_reset();
        clear_logs();
        for (int i = 0; i < 16; i++) rand_px();
        drain("t3_drain_a", 200);
        rand_px();
        rand_px();
        drive_px(12'h000, 12'h000, 12'hFFF, 11'd5, 11'd7);
        drive_px(12'hFFF, 12'h000, 12'h000, 11'd0, 11'd0);
        for (int i = 0; i < 15; i++) drive_px(12'h000, 12'hFFF, 12'h000, 11'(i + 1), 11'd0);
        drain("t3_drain_b", 200);
        chk("t3_bursts", 32'(aw_log.size()), 2);
        if (aw_log.size() >= 2) begin
            chk("t3_addr0", aw_log[0], BASE);
            chk("t3_restart_addr", aw_log[1], BASE);
        end
        if (w_log.size() >= 11) begin
            chk("t3_start_word", w_log[9], 32'h07E0_F800);
            chk("t3_next_word", w_log[10], 32'h07E0_07E0);
        end
        chk("t3_no_frame_done", 32'(fd_count), 0);

        // asynchronous reset in the middle of a data phase
        for (int i = 0; i < 16; i++) drive_px(12'hFFF, 12'hFFF, 12'hFFF, 11'(i + 1), 11'd3);
        idle(0);
        wait_wvalid("t4_wvalid", 50);
        repeat (2) @(posedge iCLK);
        @(posedge iCLK);
        #2;
        iRST = 1'b1;
        #1;
        chk("t4_async_wvalid", 32'(oWVALID), 0);
        chk("t4_async_awvalid", 32'(oAWVALID), 0);
        chk("t4_async_bready", 32'(oBREADY), 0);
        cyc();
        iRST = 1'b0;
        clear_logs();
        for (int i = 0; i < 16; i++) drive_px(12'h000, 12'h000, 12'hFFF, 11'(i + 1), 11'd4);
        drain("t4_drain", 200);
        chk("t4_bursts", 32'(aw_log.size()), 1);
        if (aw_log.size() >= 1) chk("t4_addr", aw_log[0], BASE);
        foreach (w_log[i]) chk("t4_wdata", w_log[i], 32'h001F_001F);

        // slow address and response channels
        clear_logs();
        aw_delay = 5;
        b_delay  = 3;
        for (int i = 0; i < 16; i++) rand_px();
        drain("t5_drain", 200);
        chk("t5_aw_cycles", 32'(aw_hi), 6);
        chk("t5_b_cycles", 32'(b_hi), 4);
        if (aw_log.size() >= 1) chk("t5_addr", aw_log[0], BASE + 32'h20);
        chk("t5_beats", 32'(w_log.size()), 8);
        aw_delay = 0;
        b_delay  = 0;

        // randomized traffic with random handshakes and occasional frame starts
        rnd_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else if ($urandom_range(0, 149) == 0)
                drive_px(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                         12'($urandom_range(0, 4095)), 11'd0, 11'd0);
            else rand_px();
        end
        rnd_mode = 0;
        drain("t6_drain", 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
